// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage.
package wb_pkg;

    // Control states of the write-back sequencer.
    typedef enum logic [0:0] {
        WB_RUN     = 1'b0,
        WB_WAIT_LD = 1'b1
    } wb_state_e;

    // Default index of the link register written by a call.
    localparam int WB_RA_IDX_DEF = 15;
    // Default byte offset from a call's PC to its return address.
    localparam int WB_PC_INC_DEF = 4;

    // Width of a register index for a file of nreg entries.
    function automatic int wb_rw(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/wb_result_sel.sv
// Combinational result selection: destination address, write data and the
// final write qualifier for one retiring instruction.
module wb_result_sel
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RW      = 4,
    parameter int RA_IDX  = WB_RA_IDX_DEF,
    parameter int PC_INC  = WB_PC_INC_DEF,
    parameter bit ZERO_HW = 1'b0
) (
    input  logic              is_wb,
    input  logic              is_call,
    input  logic              is_ld,
    input  logic [RW-1:0]     rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] ld_data,
    output logic [RW-1:0]     addr,
    output logic [DATA_W-1:0] data,
    output logic              we,
    output logic              is_load
);

    // Call takes precedence over load; a load only waits when it is not a call.
    always_comb begin
        addr    = rd;
        data    = alu_result;
        is_load = 1'b0;
        if (is_call) begin
            addr = RW'(RA_IDX);
            data = pc + DATA_W'(PC_INC);
        end else if (is_ld) begin
            data    = ld_data;
            is_load = 1'b1;
        end
        // A hard-wired register 0 swallows the write but the instruction still retires.
        we = is_wb && !(ZERO_HW && (addr == '0));
    end

endmodule

// File: rtl/wb_stage_unit.sv
// Write-back stage: accepts one retiring instruction per cycle, issues a
// registered register-file write, stalls for late load data and counts retirements.
module wb_stage_unit
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREG    = 16,
    parameter int RA_IDX  = WB_RA_IDX_DEF,
    parameter int PC_INC  = WB_PC_INC_DEF,
    parameter bit ZERO_HW = 1'b0,
    parameter int CNT_W   = 32,
    localparam int RW     = wb_rw(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_wb,
    input  logic              in_is_call,
    input  logic              in_is_ld,
    input  logic [RW-1:0]     in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [RW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ld_pending,
    output logic [RW-1:0]     ld_pending_rd,
    output logic [CNT_W-1:0]  retire_count,
    output logic              err_ld_call
);

    wb_state_e         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [RW-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pend_q, pend_d;
    logic [RW-1:0]     pend_rd_q, pend_rd_d;
    logic              pend_we_q, pend_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [RW-1:0]     sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_we;
    logic              sel_is_load;

    wb_result_sel #(
        .DATA_W  (DATA_W),
        .RW      (RW),
        .RA_IDX  (RA_IDX),
        .PC_INC  (PC_INC),
        .ZERO_HW (ZERO_HW)
    ) u_sel (
        .is_wb      (in_is_wb),
        .is_call    (in_is_call),
        .is_ld      (in_is_ld),
        .rd         (in_rd),
        .alu_result (in_alu_result),
        .pc         (in_pc),
        .ld_data    (ld_data),
        .addr       (sel_addr),
        .data       (sel_data),
        .we         (sel_we),
        .is_load    (sel_is_load)
    );

    assign in_ready = (state_q == WB_RUN);

    // Next-state, write and scoreboard logic; flush overrides everything but reset.
    always_comb begin
        state_d   = state_q;
        rf_we_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pend_d    = pend_q;
        pend_rd_d = pend_rd_q;
        pend_we_d = pend_we_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (flush) begin
            state_d = WB_RUN;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                WB_RUN: begin
                    if (in_valid) begin
                        if (in_is_ld && in_is_call) begin
                            err_d = 1'b1;
                        end
                        if (sel_is_load && !ld_valid) begin
                            // Data not back yet: park the destination for decode's interlock.
                            state_d   = WB_WAIT_LD;
                            pend_d    = 1'b1;
                            pend_rd_d = in_rd;
                            pend_we_d = sel_we;
                        end else begin
                            rf_we_d = sel_we;
                            if (sel_we) begin
                                waddr_d = sel_addr;
                                wdata_d = sel_data;
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WB_WAIT_LD: begin
                    if (ld_valid) begin
                        rf_we_d = pend_we_q;
                        if (pend_we_q) begin
                            waddr_d = pend_rd_q;
                            wdata_d = ld_data;
                        end
                        cnt_d   = cnt_q + CNT_W'(1);
                        pend_d  = 1'b0;
                        state_d = WB_RUN;
                    end
                end
                default: state_d = WB_RUN;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WB_RUN;
            rf_we_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pend_q    <= 1'b0;
            pend_rd_q <= '0;
            pend_we_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pend_q    <= pend_d;
            pend_rd_q <= pend_rd_d;
            pend_we_q <= pend_we_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_waddr      = waddr_q;
    assign rf_wdata      = wdata_q;
    assign ld_pending    = pend_q;
    assign ld_pending_rd = pend_rd_q;
    assign retire_count  = cnt_q;
    assign err_ld_call   = err_q;

endmodule

// File: tb/tb_wb_stage_unit.sv
// Directed bench for the write-back stage (register 0 hard-wired).
module tb_wb_stage_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_wb;
    logic        in_is_call;
    logic        in_is_ld;
    logic [3:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ld_pending;
    logic [3:0]  ld_pending_rd;
    logic [31:0] retire_count;
    logic        err_ld_call;

    int checks   = 0;
    int failures = 0;

    wb_stage_unit #(
        .DATA_W  (32),
        .NREG    (16),
        .RA_IDX  (15),
        .PC_INC  (4),
        .ZERO_HW (1'b1),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_wb      (in_is_wb),
        .in_is_call    (in_is_call),
        .in_is_ld      (in_is_ld),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .ld_pending    (ld_pending),
        .ld_pending_rd (ld_pending_rd),
        .retire_count  (retire_count),
        .err_ld_call   (err_ld_call)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic call, input logic ld,
                         input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] pc);
        in_valid = v; in_is_wb = wb; in_is_call = call; in_is_ld = ld;
        in_rd = rd; in_alu_result = alu; in_pc = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ld_valid = 1'b0; ld_data = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        step(); step();
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_pend", 32'(ld_pending), 32'h0);
        chk("rst_cnt", retire_count, 32'h0);
        chk("rst_err", 32'(err_ld_call), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        reset = 1'b0;
        $display("txn reset released");

        // ALU write
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_1234, 32'h0);
        step();
        chk("alu_we", 32'(rf_we), 32'h1);
        chk("alu_waddr", 32'(rf_waddr), 32'h3);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_cnt", retire_count, 32'h1);
        in_valid = 1'b0;
        step();
        chk("alu_pulse", 32'(rf_we), 32'h0);
        chk("alu_hold", 32'(rf_waddr), 32'h3);
        $display("txn alu r3=0x1234");

        // Calls, second one wraps the link value
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 32'hAAAA_AAAA, 32'h0000_0100);
        step();
        chk("call_we", 32'(rf_we), 32'h1);
        chk("call_waddr", 32'(rf_waddr), 32'hF);
        chk("call_wdata", rf_wdata, 32'h104);
        chk("call_cnt", retire_count, 32'h2);
        in_pc = 32'hFFFF_FFFC;
        step();
        chk("callwrap_we", 32'(rf_we), 32'h1);
        chk("callwrap_wdata", rf_wdata, 32'h0);
        chk("callwrap_cnt", retire_count, 32'h3);
        $display("txn calls pc=0x100 and pc=0xFFFFFFFC");

        // Back-to-back ALU ops
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'hA, 32'h0);
        step();
        chk("b2b1_waddr", 32'(rf_waddr), 32'h1);
        chk("b2b1_wdata", rf_wdata, 32'hA);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'hB, 32'h0);
        step();
        chk("b2b2_we", 32'(rf_we), 32'h1);
        chk("b2b2_waddr", 32'(rf_waddr), 32'h2);
        chk("b2b2_wdata", rf_wdata, 32'hB);
        chk("b2b2_cnt", retire_count, 32'h5);
        in_valid = 1'b0;
        step();
        chk("b2b_idle_we", 32'(rf_we), 32'h0);
        $display("txn back-to-back r1,r2");

        // Late load to r5
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_ready", 32'(in_ready), 32'h0);
            chk("ld_pend", 32'(ld_pending), 32'h1);
            chk("ld_pend_rd", 32'(ld_pending_rd), 32'h5);
            chk("ld_wait_we", 32'(rf_we), 32'h0);
            if (i < 2) step();
        end
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        step();
        ld_valid = 1'b0;
        chk("ld_we", 32'(rf_we), 32'h1);
        chk("ld_waddr", 32'(rf_waddr), 32'h5);
        chk("ld_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("ld_pend_clr", 32'(ld_pending), 32'h0);
        chk("ld_ready_back", 32'(in_ready), 32'h1);
        chk("ld_cnt", retire_count, 32'h6);
        $display("txn late load r5=0xDEADBEEF");

        // Load with data present at accept
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h0, 32'h0);
        ld_valid = 1'b1; ld_data = 32'h77;
        step();
        chk("ldfast_we", 32'(rf_we), 32'h1);
        chk("ldfast_wdata", rf_wdata, 32'h77);
        chk("ldfast_pend", 32'(ld_pending), 32'h0);
        chk("ldfast_cnt", retire_count, 32'h7);
        // Stray load data while idle is ignored
        in_valid = 1'b0; ld_data = 32'h99;
        step();
        ld_valid = 1'b0;
        chk("stray_we", 32'(rf_we), 32'h0);
        chk("stray_wdata", rf_wdata, 32'h77);
        chk("stray_cnt", retire_count, 32'h7);
        $display("txn fast load r6=0x77, stray ld_valid");

        // Flush during the wait
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("fl_pend_pre", 32'(ld_pending), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_pend", 32'(ld_pending), 32'h0);
        chk("fl_ready", 32'(in_ready), 32'h1);
        chk("fl_we", 32'(rf_we), 32'h0);
        ld_valid = 1'b1; ld_data = 32'h1111;
        step();
        ld_valid = 1'b0;
        chk("fl_late_we", 32'(rf_we), 32'h0);
        chk("fl_cnt", retire_count, 32'h7);
        // Flush blocks acceptance in RUN
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'h5A, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flrun_we", 32'(rf_we), 32'h0);
        chk("flrun_cnt", retire_count, 32'h7);
        $display("txn flush in wait and in run");

        // Hard-wired r0 and no-write instructions still retire
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 32'h3C, 32'h0);
        step();
        chk("r10_wdata", rf_wdata, 32'h3C);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h55, 32'h0);
        step();
        chk("r0_we", 32'(rf_we), 32'h0);
        chk("r0_waddr", 32'(rf_waddr), 32'hA);
        chk("r0_cnt", retire_count, 32'h9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 32'h66, 32'h0);
        step();
        chk("nowb_we", 32'(rf_we), 32'h0);
        chk("nowb_cnt", retire_count, 32'hA);
        chk("err_clear", 32'(err_ld_call), 32'h0);
        // Load+call behaves as call and sets the sticky error
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 32'h0, 32'h0000_0200);
        step();
        in_valid = 1'b0;
        chk("ldcall_err", 32'(err_ld_call), 32'h1);
        chk("ldcall_we", 32'(rf_we), 32'h1);
        chk("ldcall_waddr", 32'(rf_waddr), 32'hF);
        chk("ldcall_wdata", rf_wdata, 32'h204);
        chk("ldcall_ready", 32'(in_ready), 32'h1);
        chk("ldcall_cnt", retire_count, 32'hB);
        step();
        chk("err_sticky", 32'(err_ld_call), 32'h1);
        $display("txn r0 suppress, no-wb, load+call");

        // Load with is_wb=0 waits, then retires without writing
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("ldnowb_pend", 32'(ld_pending), 32'h1);
        chk("ldnowb_ready", 32'(in_ready), 32'h0);
        ld_valid = 1'b1; ld_data = 32'h5;
        step();
        ld_valid = 1'b0;
        chk("ldnowb_we", 32'(rf_we), 32'h0);
        chk("ldnowb_cnt", retire_count, 32'hC);
        $display("txn load without write-back");

        // Asynchronous reset while waiting
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("ar_pend_rd_pre", 32'(ld_pending_rd), 32'hD);
        #2 reset = 1'b1;
        #1;
        chk("ar_pend", 32'(ld_pending), 32'h0);
        chk("ar_pend_rd", 32'(ld_pending_rd), 32'h0);
        chk("ar_ready", 32'(in_ready), 32'h1);
        chk("ar_cnt", retire_count, 32'h0);
        chk("ar_err", 32'(err_ld_call), 32'h0);
        chk("ar_waddr", 32'(rf_waddr), 32'h0);
        chk("ar_wdata", rf_wdata, 32'h0);
        #1 reset = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hCAFE;
        step();
        ld_valid = 1'b0;
        chk("ar_nowrite", 32'(rf_we), 32'h0);
        chk("ar_cnt_post", retire_count, 32'h0);
        $display("txn async reset mid-wait");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
